nx_indirect_sweep_sequencer: RTL and testbench
==============================================

# nx_indirect_sweep_sequencer

Hardware sweep engine that reads a contiguous range of entries out of an indirect-access table (read-only register table behind an indirect access controller) without software involvement. It issues READ commands one entry at a time, waits for the controller status, captures read data, and delivers each entry on a valid/ready stream. It sits between a local consumer (snapshot/debug-dump logic) and the command/status/read-data port of one indirect access controller. That port is dedicated to this block; software CSR access is muxed off elsewhere.

## Interface
- N_DATA_BITS, 64, width of one table entry
- N_ENTRIES, 32, table depth
- N_ADDR_BITS, 5, entry address width (>= $clog2(N_ENTRIES))
- TIMEOUT_CYCLES, 255, maximum WAIT cycles per command (used only with timeout compiled in)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: begin sweep; ignored while busy
- first_addr  in  N_ADDR_BITS  first entry, sampled on start
- last_addr  in  N_ADDR_BITS  last entry (inclusive), sampled on start
- abort  in  1  request early termination
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse: range completed normally
- error  out  1  one-cycle pulse: bad range, bad status or timeout
- err_addr  out  N_ADDR_BITS  entry associated with last error; held until next error
- ia_wr_stb  out  1  command strobe to indirect controller
- ia_cmnd_op  out  4  command opcode
- ia_cmnd_addr  out  N_ADDR_BITS  command entry address
- ia_stat_code  in  3  controller status
- ia_rd_dat  in  N_DATA_BITS  controller read data
- out_valid  out  1  stream beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  N_DATA_BITS  entry data
- out_addr  out  N_ADDR_BITS  entry address of beat
- out_last  out  1  beat is last_addr

## Operation
- States: IDLE, CMD, WAIT, PUSH.
- IDLE: on start, if first_addr > last_addr or last_addr >= N_ENTRIES -> error pulse, err_addr = first_addr, stay IDLE; else load cur_addr = first_addr, -> CMD.
- CMD: ia_wr_stb = 1 for exactly one cycle, ia_cmnd_op = CMND_OP_READ (4'h1), ia_cmnd_addr = cur_addr -> WAIT. ia_cmnd_op/addr held stable through WAIT; ia_cmnd_op = CMND_OP_NOP (4'h0) otherwise.
- WAIT: first cycle is a guard cycle (status ignored). Then STAT_BUSY (3'd1) -> stay; STAT_READY (3'd0) -> capture ia_rd_dat into out_data, -> PUSH; any other code -> error pulse, err_addr = cur_addr, -> IDLE.
- PUSH: out_valid = 1, out_addr = cur_addr, out_last = (cur_addr == last_addr). On out_valid && out_ready: if out_last -> done pulse, IDLE; else cur_addr + 1, -> CMD. out_valid/out_data/out_addr/out_last stable until accepted.
- cur_addr never increments past last_addr; last_addr = N_ENTRIES-1 = 31 must not wrap to 0.
- abort: latched in any non-IDLE state; never cuts a command or a beat. In CMD/WAIT: command completes, data discarded, -> IDLE. In PUSH: current beat completes, -> IDLE. No done pulse on abort. abort in IDLE ignored. abort and start same cycle in IDLE: start wins.
- busy = (state != IDLE).
- start while busy ignored, no error.

## Timing
- All outputs registered. Reset: state IDLE, busy 0, done 0, error 0, err_addr 0, ia_wr_stb 0, ia_cmnd_op 0, ia_cmnd_addr 0, out_valid 0, out_data 0, out_addr 0, out_last 0.
- start at cycle 0 -> busy and ia_wr_stb high cycle 1 -> WAIT cycles 2.. (cycle 2 guard) -> earliest READY sample cycle 3 -> out_valid cycle 4.
- Minimum 4 cycles per entry with immediate READY and out_ready held high.
- done/error asserted in the cycle busy falls.
- Reset mid-sweep: immediate return to reset values; no beat, done or error emitted.

## Configuration
- NX_INDIRECT_SWEEP_TIMEOUT_EN defined: WAIT counts cycles after the guard cycle; reaching TIMEOUT_CYCLES while BUSY -> error pulse, err_addr = cur_addr, -> IDLE (pending abort also cleared).
- Undefined: no counter; WAIT waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Package nx_indirect_sweep_pkg: sweep_state_t enum, CMND_OP_NOP/CMND_OP_READ, STAT_READY/STAT_BUSY constants.
- One sub-module: nx_indirect_sweep_timer (clear/enable/expired timeout counter), instantiated only under NX_INDIRECT_SWEEP_TIMEOUT_EN.

## Test plan
- first=2, last=5, controller READY 2 cycles after strobe, out_ready=1 -> 4 beats addr 2..5, out_last on 5 only, done once, no error.
- first=30, last=31, out_ready low 10 cycles on first beat -> beat 30 held stable 10 cycles, then beat 31 with out_last, no wrap to 0.
- first=7, last=3 -> error next cycle, err_addr=7, busy never asserted, no strobe.
- Controller returns stat 3'd4 on entry 9 of range 8..12 -> beat 8 only, error, err_addr=9, busy low.
- abort asserted in WAIT of entry 4 (range 0..10) -> command completes, no beat for 4, IDLE, no done.
- Timeout build, TIMEOUT_CYCLES=16, stat held BUSY -> error 17 cycles after guard cycle, err_addr = cur_addr; non-timeout build -> busy stays high.

Source files
------------

// File: rtl/nx_indirect_sweep_pkg.sv
// rtl/nx_indirect_sweep_pkg.sv - shared types and constants for the indirect table sweep engine
package nx_indirect_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WAIT,
      ST_PUSH
   } sweep_state_t;

   localparam logic [3:0] CMND_OP_NOP  = 4'h0;
   localparam logic [3:0] CMND_OP_READ = 4'h1;

   localparam logic [2:0] STAT_READY = 3'd0;
   localparam logic [2:0] STAT_BUSY  = 3'd1;

endpackage

// File: rtl/nx_indirect_sweep_if.sv
// rtl/nx_indirect_sweep_if.sv - control, indirect controller and output stream bundle of the sweep engine
interface nx_indirect_sweep_if #(
   parameter int N_DATA_BITS = 64,
   parameter int N_ADDR_BITS = 5
);
   logic                   start;
   logic [N_ADDR_BITS-1:0] first_addr;
   logic [N_ADDR_BITS-1:0] last_addr;
   logic                   abort;
   logic                   busy;
   logic                   done;
   logic                   error;
   logic [N_ADDR_BITS-1:0] err_addr;

   logic                   ia_wr_stb;
   logic [3:0]             ia_cmnd_op;
   logic [N_ADDR_BITS-1:0] ia_cmnd_addr;
   logic [2:0]             ia_stat_code;
   logic [N_DATA_BITS-1:0] ia_rd_dat;

   logic                   out_valid;
   logic                   out_ready;
   logic [N_DATA_BITS-1:0] out_data;
   logic [N_ADDR_BITS-1:0] out_addr;
   logic                   out_last;

   // Sequencer side
   modport master (
      input  start, first_addr, last_addr, abort,
      output busy, done, error, err_addr,
      output ia_wr_stb, ia_cmnd_op, ia_cmnd_addr,
      input  ia_stat_code, ia_rd_dat,
      output out_valid, out_data, out_addr, out_last,
      input  out_ready
   );

   // Consumer / controller side
   modport slave (
      output start, first_addr, last_addr, abort,
      input  busy, done, error, err_addr,
      input  ia_wr_stb, ia_cmnd_op, ia_cmnd_addr,
      output ia_stat_code, ia_rd_dat,
      input  out_valid, out_data, out_addr, out_last,
      output out_ready
   );
endinterface

// File: rtl/nx_indirect_sweep_timer.sv
// rtl/nx_indirect_sweep_timer.sv - saturating WAIT timeout counter, used when NX_INDIRECT_SWEEP_TIMEOUT_EN is defined
module nx_indirect_sweep_timer #(
   parameter int CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Expires in the CYCLES-th enabled cycle so the caller can act in that same cycle
   assign expired_o = en_i && (count_q == W'(CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && !expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/nx_indirect_sweep_sequencer.sv
// rtl/nx_indirect_sweep_sequencer.sv - reads an entry range through an indirect controller and streams it out
// Optional WAIT timeout compiled in with NX_INDIRECT_SWEEP_TIMEOUT_EN.
module nx_indirect_sweep_sequencer
   import nx_indirect_sweep_pkg::*;
#(
   parameter int N_DATA_BITS    = 64,
   parameter int N_ENTRIES      = 32,
   parameter int N_ADDR_BITS    = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   nx_indirect_sweep_if.master sw
);
   localparam logic [N_ADDR_BITS:0] ENTRIES_W = (N_ADDR_BITS + 1)'(N_ENTRIES);

   sweep_state_t           state_q, state_d;
   logic [N_ADDR_BITS-1:0] cur_q, cur_d;
   logic [N_ADDR_BITS-1:0] last_q, last_d;
   logic                   abort_q, abort_d;
   logic                   guard_q, guard_d;
   logic                   abort_pend;
   logic                   timer_expired;

   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic [N_ADDR_BITS-1:0] err_addr_q, err_addr_d;
   logic                   stb_q, stb_d;
   logic [3:0]             op_q, op_d;
   logic [N_ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;
   logic                   out_valid_q, out_valid_d;
   logic [N_DATA_BITS-1:0] out_data_q, out_data_d;
   logic [N_ADDR_BITS-1:0] out_addr_q, out_addr_d;
   logic                   out_last_q, out_last_d;

`ifdef NX_INDIRECT_SWEEP_TIMEOUT_EN
   logic timer_run;

   assign timer_run = (state_q == ST_WAIT) && !guard_q;

   nx_indirect_sweep_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (!timer_run),
      .en_i      (timer_run),
      .expired_o (timer_expired)
   );
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timer_expired      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      abort_d    = abort_q;
      guard_d    = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_addr_d = err_addr_q;
      out_data_d = out_data_q;
      abort_pend = abort_q | sw.abort;

      case (state_q)
         ST_IDLE: begin
            // start wins over a coincident abort; abort is only latched once busy
            abort_d = 1'b0;
            if (sw.start) begin
               if ((sw.first_addr > sw.last_addr) || ({1'b0, sw.last_addr} >= ENTRIES_W)) begin
                  error_d    = 1'b1;
                  err_addr_d = sw.first_addr;
               end else begin
                  cur_d   = sw.first_addr;
                  last_d  = sw.last_addr;
                  state_d = ST_CMD;
               end
            end
         end

         ST_CMD: begin
            abort_d = abort_pend;
            guard_d = 1'b1;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            abort_d = abort_pend;
            // The controller status is stale in the cycle right after the strobe
            if (!guard_q) begin
               if (sw.ia_stat_code == STAT_BUSY) begin
                  if (timer_expired) begin
                     error_d    = 1'b1;
                     err_addr_d = cur_q;
                     abort_d    = 1'b0;
                     state_d    = ST_IDLE;
                  end
               end else if (sw.ia_stat_code == STAT_READY) begin
                  if (abort_pend) begin
                     abort_d = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     out_data_d = sw.ia_rd_dat;
                     state_d    = ST_PUSH;
                  end
               end else begin
                  error_d    = 1'b1;
                  err_addr_d = cur_q;
                  abort_d    = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end

         ST_PUSH: begin
            abort_d = abort_pend;
            if (sw.out_ready) begin
               if (out_last_q) begin
                  done_d  = !abort_pend;
                  state_d = ST_IDLE;
               end else if (abort_pend) begin
                  state_d = ST_IDLE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = ST_CMD;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Every output is a flop loaded from the next state
   always_comb begin
      busy_d      = (state_d != ST_IDLE);
      stb_d       = (state_d == ST_CMD);
      op_d        = ((state_d == ST_CMD) || (state_d == ST_WAIT)) ? CMND_OP_READ : CMND_OP_NOP;
      cmd_addr_d  = (state_d == ST_CMD) ? cur_d : cmd_addr_q;
      out_valid_d = (state_d == ST_PUSH);
      out_addr_d  = (state_d == ST_PUSH) ? cur_d : out_addr_q;
      out_last_d  = (state_d == ST_PUSH) && (cur_d == last_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         last_q      <= '0;
         abort_q     <= 1'b0;
         guard_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_addr_q  <= '0;
         stb_q       <= 1'b0;
         op_q        <= CMND_OP_NOP;
         cmd_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         abort_q     <= abort_d;
         guard_q     <= guard_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_addr_q  <= err_addr_d;
         stb_q       <= stb_d;
         op_q        <= op_d;
         cmd_addr_q  <= cmd_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_last_q  <= out_last_d;
      end
   end

   assign sw.busy         = busy_q;
   assign sw.done         = done_q;
   assign sw.error        = error_q;
   assign sw.err_addr     = err_addr_q;
   assign sw.ia_wr_stb    = stb_q;
   assign sw.ia_cmnd_op   = op_q;
   assign sw.ia_cmnd_addr = cmd_addr_q;
   assign sw.out_valid    = out_valid_q;
   assign sw.out_data     = out_data_q;
   assign sw.out_addr     = out_addr_q;
   assign sw.out_last     = out_last_q;
endmodule

// File: tb/tb_nx_indirect_sweep_sequencer.sv
// tb/tb_nx_indirect_sweep_sequencer.sv - self-checking bench for the indirect table sweep engine
module tb_nx_indirect_sweep_sequencer;
   import nx_indirect_sweep_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nx_indirect_sweep_if #(.N_DATA_BITS(64), .N_ADDR_BITS(5)) sw ();

   nx_indirect_sweep_sequencer #(
      .N_DATA_BITS    (64),
      .N_ENTRIES      (32),
      .N_ADDR_BITS    (5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw)
   );

   int checks = 0;
   int errors = 0;

   // Controller model knobs
   int       lat = 2;
   int       bad_addr = -1;
   logic [2:0] bad_code = 3'd4;
   logic     hold_busy = 1'b0;
   int       ctr = 0;
   logic [4:0] cmd_a = '0;

   // Monitor state
   int beats, dones, errs, strobes, beat_bad, unstable, busy_seen;
   int exp_addr, exp_last;
   logic prev_hold = 1'b0;
   logic [4:0] prev_addr;
   logic [63:0] prev_data;
   logic prev_last;

   function automatic logic [63:0] entry_data(input logic [4:0] a);
      return {32'hC0DE_0000 | {27'd0, a}, ~{27'd0, a}};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Indirect controller: BUSY after each strobe, READY lat cycles later
   always @(negedge clk) begin
      if (!rst_n) begin
         ctr = 0;
         sw.ia_stat_code = STAT_READY;
         sw.ia_rd_dat = '0;
      end else if (sw.ia_wr_stb) begin
         ctr = lat;
         cmd_a = sw.ia_cmnd_addr;
         sw.ia_stat_code = STAT_BUSY;
      end else if (hold_busy) begin
         sw.ia_stat_code = STAT_BUSY;
      end else if (ctr > 1) begin
         ctr--;
         sw.ia_stat_code = STAT_BUSY;
      end else begin
         sw.ia_stat_code = (int'(cmd_a) == bad_addr) ? bad_code : STAT_READY;
         sw.ia_rd_dat = entry_data(cmd_a);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && !(sw.out_valid && sw.out_addr == prev_addr &&
                            sw.out_data == prev_data && sw.out_last == prev_last))
            unstable++;
         if (sw.out_valid && sw.out_ready) begin
            if (int'(sw.out_addr) != exp_addr || sw.out_data != entry_data(5'(exp_addr)) ||
                sw.out_last != (exp_addr == exp_last))
               beat_bad++;
            beats++;
            exp_addr++;
         end
         dones += int'(sw.done);
         errs += int'(sw.error);
         strobes += int'(sw.ia_wr_stb);
         busy_seen |= int'(sw.busy);
         prev_hold = sw.out_valid && !sw.out_ready;
         prev_addr = sw.out_addr;
         prev_data = sw.out_data;
         prev_last = sw.out_last;
      end
   end

   task automatic clear_mon(input int f, input int l);
      beats = 0; dones = 0; errs = 0; strobes = 0;
      beat_bad = 0; unstable = 0; busy_seen = 0;
      exp_addr = f; exp_last = l;
   endtask

   task automatic pulse_start(input int f, input int l);
      @(posedge clk); #1;
      sw.start = 1'b1;
      sw.first_addr = 5'(f);
      sw.last_addr = 5'(l);
      @(posedge clk); #1;
      sw.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      repeat (3) @(posedge clk);
      #1;
      for (n = 0; n < 600; n++) begin
         if (!sw.busy) break;
         @(posedge clk); #1;
      end
      if (n >= 600) check({name, "_idle_timeout"}, 64'(sw.busy), 64'd0);
      @(negedge clk); #1;
   endtask

   task automatic sweep(input int f, input int l, input string name);
      clear_mon(f, l);
      pulse_start(f, l);
      wait_idle(name);
   endtask

   typedef struct {
      int first, last, lat, bad_addr;
      logic [2:0] bad_code;
      int beats, dones, errs, strobes, err_addr;
   } vec_t;

   vec_t vt[6];

   initial begin
      int n;
      int ok_cnt;
      sw.start = 1'b0; sw.first_addr = '0; sw.last_addr = '0;
      sw.abort = 1'b0; sw.out_ready = 1'b1;

      vt[0] = '{first: 2,  last: 5,  lat: 2, bad_addr: -1, bad_code: 3'd4, beats: 4, dones: 1, errs: 0, strobes: 4, err_addr: 0};
      vt[1] = '{first: 7,  last: 3,  lat: 2, bad_addr: -1, bad_code: 3'd4, beats: 0, dones: 0, errs: 1, strobes: 0, err_addr: 7};
      vt[2] = '{first: 8,  last: 12, lat: 2, bad_addr: 9,  bad_code: 3'd4, beats: 1, dones: 0, errs: 1, strobes: 2, err_addr: 9};
      vt[3] = '{first: 31, last: 31, lat: 1, bad_addr: -1, bad_code: 3'd4, beats: 1, dones: 1, errs: 0, strobes: 1, err_addr: 9};
      vt[4] = '{first: 0,  last: 3,  lat: 3, bad_addr: 0,  bad_code: 3'd7, beats: 0, dones: 0, errs: 1, strobes: 1, err_addr: 0};
      vt[5] = '{first: 20, last: 23, lat: 3, bad_addr: -1, bad_code: 3'd4, beats: 4, dones: 1, errs: 0, strobes: 4, err_addr: 0};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(sw.busy), 0);
      check("rst_done", 64'(sw.done), 0);
      check("rst_error", 64'(sw.error), 0);
      check("rst_err_addr", 64'(sw.err_addr), 0);
      check("rst_stb", 64'(sw.ia_wr_stb), 0);
      check("rst_op", 64'(sw.ia_cmnd_op), 0);
      check("rst_cmd_addr", 64'(sw.ia_cmnd_addr), 0);
      check("rst_out_valid", 64'(sw.out_valid), 0);
      check("rst_out_data", sw.out_data, 0);
      check("rst_out_addr", 64'(sw.out_addr), 0);
      check("rst_out_last", 64'(sw.out_last), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         lat = vt[i].lat;
         bad_addr = vt[i].bad_addr;
         bad_code = vt[i].bad_code;
         sweep(vt[i].first, vt[i].last, $sformatf("v%0d", i));
         check($sformatf("v%0d_beats", i), 64'(beats), 64'(vt[i].beats));
         check($sformatf("v%0d_done", i), 64'(dones), 64'(vt[i].dones));
         check($sformatf("v%0d_error", i), 64'(errs), 64'(vt[i].errs));
         check($sformatf("v%0d_strobes", i), 64'(strobes), 64'(vt[i].strobes));
         check($sformatf("v%0d_err_addr", i), 64'(sw.err_addr), 64'(vt[i].err_addr));
         check($sformatf("v%0d_beat_data", i), 64'(beat_bad), 0);
         check($sformatf("v%0d_busy_seen", i), 64'(busy_seen), 64'(vt[i].strobes > 0));
      end
      bad_addr = -1;

      // Cycle-exact latency of a single-entry sweep
      lat = 2;
      clear_mon(6, 6);
      @(posedge clk); #1;
      sw.start = 1'b1; sw.first_addr = 5'd6; sw.last_addr = 5'd6;
      check("t0_busy", 64'(sw.busy), 0);
      @(posedge clk); #1;
      sw.start = 1'b0;
      check("t1_busy", 64'(sw.busy), 1);
      check("t1_stb", 64'(sw.ia_wr_stb), 1);
      check("t1_op", 64'(sw.ia_cmnd_op), 64'(CMND_OP_READ));
      check("t1_cmd_addr", 64'(sw.ia_cmnd_addr), 6);
      @(posedge clk); #1;
      check("t2_stb", 64'(sw.ia_wr_stb), 0);
      check("t2_op", 64'(sw.ia_cmnd_op), 64'(CMND_OP_READ));
      check("t2_out_valid", 64'(sw.out_valid), 0);
      @(posedge clk); #1;
      check("t3_out_valid", 64'(sw.out_valid), 0);
      @(posedge clk); #1;
      check("t4_out_valid", 64'(sw.out_valid), 1);
      check("t4_out_addr", 64'(sw.out_addr), 6);
      check("t4_out_last", 64'(sw.out_last), 1);
      check("t4_out_data", sw.out_data, entry_data(5'd6));
      @(posedge clk); #1;
      check("t5_busy", 64'(sw.busy), 0);
      check("t5_done", 64'(sw.done), 1);
      check("t5_out_valid", 64'(sw.out_valid), 0);
      check("t5_op", 64'(sw.ia_cmnd_op), 64'(CMND_OP_NOP));
      @(posedge clk); #1;
      check("t6_done", 64'(sw.done), 0);

      // Backpressure at the top of the table
      sw.out_ready = 1'b0;
      clear_mon(30, 31);
      pulse_start(30, 31);
      for (n = 0; n < 50; n++) begin
         if (sw.out_valid) break;
         @(posedge clk); #1;
      end
      check("bp_valid_seen", 64'(sw.out_valid), 1);
      ok_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (sw.out_valid && sw.out_addr == 5'd30 && !sw.out_last && sw.out_data == entry_data(5'd30))
            ok_cnt++;
      end
      check("bp_hold_cycles", 64'(ok_cnt), 10);
      sw.out_ready = 1'b1;
      wait_idle("bp");
      check("bp_beats", 64'(beats), 2);
      check("bp_done", 64'(dones), 1);
      check("bp_beat_data", 64'(beat_bad), 0);
      check("bp_unstable", 64'(unstable), 0);
      check("bp_strobes", 64'(strobes), 2);

      // Abort during WAIT of entry 4
      lat = 4;
      clear_mon(0, 10);
      pulse_start(0, 10);
      for (n = 0; n < 200; n++) begin
         if (sw.ia_wr_stb && sw.ia_cmnd_addr == 5'd4) break;
         @(posedge clk); #1;
      end
      check("ab_strobe4_seen", 64'(n < 200), 1);
      @(posedge clk); #1;
      sw.abort = 1'b1;
      @(posedge clk); #1;
      sw.abort = 1'b0;
      wait_idle("ab");
      check("ab_beats", 64'(beats), 4);
      check("ab_done", 64'(dones), 0);
      check("ab_error", 64'(errs), 0);
      check("ab_strobes", 64'(strobes), 5);
      check("ab_beat_data", 64'(beat_bad), 0);

      // Start while busy is ignored
      lat = 2;
      clear_mon(12, 13);
      pulse_start(12, 13);
      pulse_start(7, 3);
      wait_idle("sb");
      check("sb_beats", 64'(beats), 2);
      check("sb_done", 64'(dones), 1);
      check("sb_error", 64'(errs), 0);

      // Abort and start together in IDLE: start wins
      clear_mon(14, 15);
      @(posedge clk); #1;
      sw.start = 1'b1; sw.abort = 1'b1; sw.first_addr = 5'd14; sw.last_addr = 5'd15;
      @(posedge clk); #1;
      sw.start = 1'b0; sw.abort = 1'b0;
      wait_idle("as");
      check("as_beats", 64'(beats), 2);
      check("as_done", 64'(dones), 1);

      // Reset mid-sweep
      clear_mon(0, 20);
      pulse_start(0, 20);
      for (n = 0; n < 200; n++) begin
         if (beats >= 2) break;
         @(posedge clk); #1;
      end
      check("rs_progress", 64'(beats >= 2), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rs_busy", 64'(sw.busy), 0);
      check("rs_out_valid", 64'(sw.out_valid), 0);
      check("rs_stb", 64'(sw.ia_wr_stb), 0);
      check("rs_out_data", sw.out_data, 0);
      check("rs_op", 64'(sw.ia_cmnd_op), 0);
      dones = 0; errs = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rs_no_done", 64'(dones), 0);
      check("rs_no_error", 64'(errs), 0);
      check("rs_idle", 64'(sw.busy), 0);

      // Controller stuck BUSY
      hold_busy = 1'b1;
      clear_mon(5, 5);
      pulse_start(5, 5);
      for (n = 0; n < 20; n++) begin
         if (sw.ia_wr_stb) break;
         @(posedge clk); #1;
      end
      check("hb_strobe_seen", 64'(sw.ia_wr_stb), 1);
`ifdef NX_INDIRECT_SWEEP_TIMEOUT_EN
      repeat (17) @(posedge clk);
      #1;
      check("to_pre_error", 64'(sw.error), 0);
      check("to_pre_busy", 64'(sw.busy), 1);
      @(posedge clk); #1;
      check("to_error", 64'(sw.error), 1);
      check("to_err_addr", 64'(sw.err_addr), 5);
      check("to_busy", 64'(sw.busy), 0);
      hold_busy = 1'b0;
`else
      repeat (40) @(posedge clk);
      #1;
      check("hb_busy", 64'(sw.busy), 1);
      check("hb_error", 64'(errs), 0);
      hold_busy = 1'b0;
      wait_idle("hb");
      check("hb_done", 64'(dones), 1);
      check("hb_beats", 64'(beats), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
